pt_frame_seq: RTL and testbench
===============================

PT_FRAME_SEQ -- requirements
Module: pt_frame_seq

Interface
REQ-001 Parameter BIT_CYCLES, default 32, clk cycles each trit is held on state.
REQ-002 Parameter SYNC_CYCLES, default 128, clk cycles of the sync slot.
REQ-003 Parameter REPEATS, default 4, number of times one word is transmitted (range 1..15).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_word  input  24  12 trits, 2 bits each, trit 0 = in_word[23:22]; 00=0, 01=1, 10=F.
REQ-007 in_valid  input  1  in_word is valid this cycle.
REQ-008 in_ready  output  1  block accepts in_word this cycle.
REQ-009 state  output  2  trit driven to the downstream code-bit generator.
REQ-010 sb_rst  output  1  reset to the downstream sync-bit generator; low only during the sync slot.
REQ-011 sel  output  1  0 = code-bit path, 1 = sync path (select for the downstream output mux).
REQ-012 busy  output  1  high from the cycle after acceptance until frame completion.
REQ-013 frame_done  output  1  one-cycle pulse after the last sync slot of the last repeat.

Function
REQ-014 States: IDLE, BITS, SYNC; all outputs registered.
REQ-015 Handshake: transfer occurs on a rising edge where in_valid && in_ready; in_word latched in that edge.
REQ-016 IDLE: in_ready=1, state=00, sb_rst=1, sel=0, busy=0.
REQ-017 Transfer in IDLE -> BITS next cycle, trit index 0, slot counter 0, repeat counter 0; state shows trit 0 in the first cycle after the handshake (latency 1).
REQ-018 BITS: state = current trit for exactly BIT_CYCLES cycles per trit, trits 0..11 in order; sb_rst=1, sel=0.
REQ-019 Trit code 11 is driven as 10 (F).
REQ-020 After the BIT_CYCLES-th cycle of trit 11 -> SYNC: sb_rst=0, sel=1, state=00 for exactly SYNC_CYCLES cycles.
REQ-021 End of SYNC: if repeat counter < REPEATS-1, increment it and return to BITS at trit 0 with no gap cycle; else pulse frame_done and enter IDLE.
REQ-022 One frame (all repeats) lasts exactly REPEATS*(12*BIT_CYCLES+SYNC_CYCLES) cycles of busy=1; default 2048.
REQ-023 in_valid changes while busy have no effect on the transmitted word.
REQ-024 Slot counter width $clog2(max(BIT_CYCLES,SYNC_CYCLES)); wraps to 0 at each slot boundary, never overflows.
REQ-025 REPEATS=1: a single BITS+SYNC pass, then frame_done.

Reset
REQ-026 rst high forces IDLE immediately, independent of clk: in_ready=1, state=00, sb_rst=1, sel=0, busy=0, frame_done=0.
REQ-027 Reset mid-frame discards the latched word and any queued word; no frame_done is produced.
REQ-028 First transfer possible on the first rising edge after rst deasserts.

Configuration
REQ-029 Macro PT_FRAME_QUEUE_EN compiles in a one-entry queue.
REQ-030 With PT_FRAME_QUEUE_EN: in_ready=1 whenever the queue is empty (including while busy); a queued word starts BITS trit 0 in the cycle after the final SYNC cycle, frame_done still pulses, busy stays 1.
REQ-031 Without PT_FRAME_QUEUE_EN: in_ready=1 only in IDLE; at least one IDLE cycle separates frames.

Verification
REQ-032 Reset, then in_word=24'h000000 with in_valid for one cycle -> state=00 for 384 cycles, then sel=1/sb_rst=0 for 128 cycles, repeated 4 times, frame_done at cycle 2049 after handshake.
REQ-033 in_word=24'h5A5A5A -> state sequence per repeat 01,01,10,10,01,01,10,10,01,01,10,10, each 32 cycles.
REQ-034 in_word=24'hFFFFFF -> every trit driven as 10.
REQ-035 rst asserted at cycle 700 of a frame -> outputs at IDLE values same cycle, no frame_done, new word accepted after release.
REQ-036 With PT_FRAME_QUEUE_EN, second word presented at cycle 100 -> in_ready=1, accepted, BITS restarts immediately after frame 1 with busy never dropping; without macro, in_ready=0 until IDLE.
REQ-037 REPEATS=1, BIT_CYCLES=4, SYNC_CYCLES=16 -> busy for exactly 64 cycles, one frame_done pulse.

Source files
------------

// File: rtl/pt_frame_seq.sv
// Frame sequencer: sends a 12-trit word REPEATS times, each pass being 12 trit slots followed by a sync slot.
// Optional one-entry input queue is compiled in with the PT_FRAME_QUEUE_EN macro.
module pt_frame_seq #(
  parameter int BIT_CYCLES  = 32,
  parameter int SYNC_CYCLES = 128,
  parameter int REPEATS     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] in_word,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [1:0]  state,
  output logic        sb_rst,
  output logic        sel,
  output logic        busy,
  output logic        frame_done
);

  localparam int MAX_CYCLES = (BIT_CYCLES > SYNC_CYCLES) ? BIT_CYCLES : SYNC_CYCLES;
  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_CYCLES - 1);
  localparam logic [3:0]    REP_LAST  = 4'(REPEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_BITS, S_SYNC} fsm_t;

  fsm_t          st_q, st_d;
  logic [23:0]   word_q, word_d;
  logic [3:0]    trit_q, trit_d;
  logic [CW-1:0] slot_q, slot_d;
  logic [3:0]    rep_q, rep_d;
  logic [1:0]    state_q, state_d;
  logic          sb_rst_q, sb_rst_d;
  logic          sel_q, sel_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic          in_ready_q, in_ready_d;
  logic          xfer, start, end_frame;
  logic [23:0]   start_word;
`ifdef PT_FRAME_QUEUE_EN
  logic [23:0]   qword_q, qword_d;
  logic          qfull_q, qfull_d;
`endif

  // Trit idx of word, with the unused code 11 folded onto F (10).
  function automatic logic [1:0] trit_of(input logic [23:0] w, input logic [3:0] idx);
    logic [23:0] s;
    s = w << {idx, 1'b0};
    trit_of = (s[23:22] == 2'b11) ? 2'b10 : s[23:22];
  endfunction

  always_comb begin
    st_d         = st_q;
    word_d       = word_q;
    trit_d       = trit_q;
    slot_d       = slot_q;
    rep_d        = rep_q;
    state_d      = state_q;
    frame_done_d = 1'b0;
    start        = 1'b0;
    start_word   = in_word;
    end_frame    = 1'b0;
`ifdef PT_FRAME_QUEUE_EN
    qword_d      = qword_q;
    qfull_d      = qfull_q;
`endif
    xfer = in_valid && in_ready_q;

    case (st_q)
      S_BITS: begin
        if (slot_q == BIT_LAST) begin
          slot_d = '0;
          if (trit_q == 4'd11) begin
            st_d    = S_SYNC;
            state_d = 2'b00;
          end else begin
            trit_d  = trit_q + 4'd1;
            state_d = trit_of(word_q, trit_q + 4'd1);
          end
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      S_SYNC: begin
        if (slot_q == SYNC_LAST) begin
          slot_d = '0;
          if (rep_q != REP_LAST) begin
            rep_d   = rep_q + 4'd1;
            st_d    = S_BITS;
            trit_d  = 4'd0;
            state_d = trit_of(word_q, 4'd0);
          end else begin
            frame_done_d = 1'b1;
            end_frame    = 1'b1;
            st_d         = S_IDLE;
            state_d      = 2'b00;
          end
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      default: start = xfer;
    endcase

`ifdef PT_FRAME_QUEUE_EN
    // A word arriving on the last sync edge bypasses the queue and starts directly.
    if (end_frame) begin
      if (qfull_q) begin
        start      = 1'b1;
        start_word = qword_q;
        qfull_d    = 1'b0;
      end else begin
        start = xfer;
      end
    end else if (xfer && st_q != S_IDLE) begin
      qword_d = in_word;
      qfull_d = 1'b1;
    end
`endif

    if (start) begin
      st_d    = S_BITS;
      word_d  = start_word;
      trit_d  = 4'd0;
      slot_d  = '0;
      rep_d   = 4'd0;
      state_d = trit_of(start_word, 4'd0);
    end

    busy_d   = (st_d != S_IDLE);
    sb_rst_d = (st_d != S_SYNC);
    sel_d    = (st_d == S_SYNC);
`ifdef PT_FRAME_QUEUE_EN
    in_ready_d = !qfull_d;
`else
    in_ready_d = (st_d == S_IDLE);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q         <= S_IDLE;
      word_q       <= '0;
      trit_q       <= '0;
      slot_q       <= '0;
      rep_q        <= '0;
      state_q      <= 2'b00;
      sb_rst_q     <= 1'b1;
      sel_q        <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      in_ready_q   <= 1'b1;
`ifdef PT_FRAME_QUEUE_EN
      qword_q      <= '0;
      qfull_q      <= 1'b0;
`endif
    end else begin
      st_q         <= st_d;
      word_q       <= word_d;
      trit_q       <= trit_d;
      slot_q       <= slot_d;
      rep_q        <= rep_d;
      state_q      <= state_d;
      sb_rst_q     <= sb_rst_d;
      sel_q        <= sel_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      in_ready_q   <= in_ready_d;
`ifdef PT_FRAME_QUEUE_EN
      qword_q      <= qword_d;
      qfull_q      <= qfull_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign state      = state_q;
  assign sb_rst     = sb_rst_q;
  assign sel        = sel_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pt_frame_seq.sv
// Directed bench for pt_frame_seq: vector table of words vs. hand-computed trit streams,
// plus reset, back-to-back word and short-frame sequences.
module tb_pt_frame_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [23:0] in_word, s_in_word;
  logic        in_valid, s_in_valid;
  logic        in_ready, sb_rst, sel, busy, frame_done;
  logic [1:0]  state;
  logic        s_in_ready, s_sb_rst, s_sel, s_busy, s_frame_done;
  logic [1:0]  s_state;
  logic [6:0]  outs, s_outs;

  int total = 0;
  int bad   = 0;

  pt_frame_seq dut (
    .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
    .state(state), .sb_rst(sb_rst), .sel(sel), .busy(busy), .frame_done(frame_done)
  );

  pt_frame_seq #(.BIT_CYCLES(4), .SYNC_CYCLES(16), .REPEATS(1)) u_small (
    .clk(clk), .rst(rst), .in_word(s_in_word), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .state(s_state), .sb_rst(s_sb_rst), .sel(s_sel), .busy(s_busy), .frame_done(s_frame_done)
  );

  // {in_ready, state, sb_rst, sel, busy, frame_done}
  assign outs   = {in_ready, state, sb_rst, sel, busy, frame_done};
  assign s_outs = {s_in_ready, s_state, s_sb_rst, s_sel, s_busy, s_frame_done};

  localparam logic [6:0] IDLE_V = 7'b1001000;
  localparam logic [6:0] DONE_V = 7'b1001001;
`ifdef PT_FRAME_QUEUE_EN
  localparam logic BUSY_READY = 1'b1;
`else
  localparam logic BUSY_READY = 1'b0;
`endif

  typedef struct {
    logic [23:0] word;
    logic [23:0] exp_trits;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 20) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge while idle; returns at the negedge of cycle 1 after the handshake.
  task automatic send(input logic [23:0] w);
    chk("ready before send", 32'(in_ready), 32'd1);
    in_word  = w;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Checks every cycle of a default-parameter frame, starting at cycle 1 after the handshake.
  task automatic run_frame(input logic [23:0] w, input logic [23:0] exp_trits, input bit junk,
                           input string tag);
    logic [6:0] e;
    logic [1:0] t;
    int pos;
    for (int k = 1; k <= 2050; k++) begin
      pos = (k - 1) % 512;
      if (k == 2049) e = DONE_V;
      else if (k == 2050) e = IDLE_V;
      else if (pos < 384) begin
        t = exp_trits[23 - 2*(pos/32) -: 2];
        e = {BUSY_READY, t, 1'b1, 1'b0, 1'b1, 1'b0};
      end else begin
        e = {BUSY_READY, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0};
      end
      chk($sformatf("%s cyc%0d", tag, k), 32'(outs), 32'(e));
      if (junk && k < 2048) begin
        in_valid = 1'b1;
        in_word  = ~w;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    vec_t vecs [5];
    int n, drops, busy_cnt, fd_cnt;
    bit junk;

    vecs[0] = '{24'h000000, 24'h000000};
    vecs[1] = '{24'h5A5A5A, 24'h5A5A5A};
    vecs[2] = '{24'hFFFFFF, 24'hAAAAAA};
    vecs[3] = '{24'hE4E4E4, 24'hA4A4A4};
    vecs[4] = '{24'h123456, 24'h122456};
`ifdef PT_FRAME_QUEUE_EN
    junk = 1'b0;
`else
    junk = 1'b1;
`endif

    rst = 1'b1; in_valid = 1'b0; in_word = '0; s_in_valid = 1'b0; s_in_word = '0;
    repeat (3) @(negedge clk);
    chk("reset outs", 32'(outs), 32'(IDLE_V));
    chk("reset small outs", 32'(s_outs), 32'(IDLE_V));
    rst = 1'b0;
    @(negedge clk);
    chk("idle after reset", 32'(outs), 32'(IDLE_V));

    for (int i = 0; i < 5; i++) begin
      send(vecs[i].word);
      run_frame(vecs[i].word, vecs[i].exp_trits, junk, $sformatf("vec%0d", i));
    end

    // Reset at cycle 700, then transfer on the first edge after release.
    send(24'h5A5A5A);
    repeat (699) @(negedge clk);
    chk("busy at cyc700", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1 chk("async reset outs", 32'(outs), 32'(IDLE_V));
    @(negedge clk);
    chk("held reset outs", 32'(outs), 32'(IDLE_V));
    rst = 1'b0; in_word = 24'hFFFFFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    run_frame(24'hFFFFFF, 24'hAAAAAA, 1'b0, "post-reset");

    // Second word offered at cycle 100 of a frame.
    send(24'h000000);
    repeat (99) @(negedge clk);
`ifdef PT_FRAME_QUEUE_EN
    chk("q ready at cyc100", 32'(in_ready), 32'd1);
    in_word = 24'hFFFFFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("q full ready", 32'(in_ready), 32'd0);
    drops = 0;
    for (int k = 101; k <= 2048; k++) begin
      if (!busy) drops++;
      @(negedge clk);
    end
    chk("q busy drops", 32'(drops), 32'd0);
    chk("q handover", 32'(outs), 32'(7'b1101011));
    repeat (2048) @(negedge clk);
    chk("q second done", 32'(outs), 32'(DONE_V));
`else
    chk("nq ready at cyc100", 32'(in_ready), 32'd0);
    in_word = 24'hFFFFFF; in_valid = 1'b1;
    n = 100;
    while (!in_ready && n < 2200) begin
      @(negedge clk);
      n++;
    end
    chk("nq ready cycle", 32'(n), 32'd2049);
    chk("nq done at ready", 32'(outs), 32'(DONE_V));
    @(negedge clk);
    in_valid = 1'b0;
    chk("nq second start", 32'(outs), 32'(7'b0101010));
    repeat (2048) @(negedge clk);
    chk("nq second done", 32'(outs), 32'(DONE_V));
`endif
    @(negedge clk);
    chk("idle after pair", 32'(outs), 32'(IDLE_V));

    // Short single-repeat frame on the small instance.
    chk("small ready", 32'(s_in_ready), 32'd1);
    s_in_word = 24'h400000; s_in_valid = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0;
    chk("small first trit", 32'(s_state), 32'd1);
    busy_cnt = 0; fd_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      if (s_busy) busy_cnt++;
      if (s_frame_done) fd_cnt++;
      @(negedge clk);
    end
    chk("small busy cycles", 32'(busy_cnt), 32'd64);
    chk("small frame_done pulses", 32'(fd_cnt), 32'd1);
    chk("small idle", 32'(s_outs), 32'(IDLE_V));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
